// File: rtl/game_pkg.sv
// game_pkg: shared game types, screen/obstacle geometry and spawn timing helpers
package game_pkg;
  typedef enum logic [1:0] {GAME_IDLE, GAME_PLAY, GAME_OVER} game_state_t;
  typedef enum logic [1:0] {WAIT, SCAN, SPAWN, HIT} sched_state_t;
  localparam int SCREEN_W = 640;
  localparam int OBST_W = 16;
  localparam int BALL_R = 4;
  localparam int NUM_SLOTS = 4;
  localparam int LANE_Y_BASE = 64;
  localparam int LANE_Y_PITCH = 96;
  function automatic logic [5:0] spawn_period(input logic [1:0] spd);
    return spd == 2'd3 ? 6'd16 : spd == 2'd2 ? 6'd32 : 6'd48;
  endfunction
  function automatic logic [9:0] lane_y(input logic [1:0] lane);
    return 10'(LANE_Y_BASE + LANE_Y_PITCH * int'(lane));
  endfunction
endpackage

// File: rtl/obstacle_hit_check.sv
// obstacle_hit_check: ball-vs-obstacle box overlap using 11-bit unsigned compares
module obstacle_hit_check #(
  parameter int OBST_W = game_pkg::OBST_W,
  parameter int BALL_R = game_pkg::BALL_R
) (
  input  logic [9:0] obj_x_i,
  input  logic [9:0] obj_y_i,
  input  logic [9:0] ball_x_i,
  input  logic [9:0] ball_y_i,
  output logic       hit_o
);
  logic [10:0] bx, by, ox, oy;
  assign bx = {1'b0, ball_x_i};
  assign by = {1'b0, ball_y_i};
  assign ox = {1'b0, obj_x_i};
  assign oy = {1'b0, obj_y_i};
  assign hit_o = (bx + 11'(BALL_R) >= ox) && (bx < ox + 11'(OBST_W + BALL_R)) &&
                 (by + 11'(BALL_R) >= oy) && (by < oy + 11'(OBST_W + BALL_R));
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame obstacle mover, spawner and ball collision detector
module obstacle_scheduler #(
  parameter int NUM_SLOTS = game_pkg::NUM_SLOTS,
  parameter int SCREEN_W = game_pkg::SCREEN_W,
  parameter int OBST_W = game_pkg::OBST_W,
  parameter int BALL_R = game_pkg::BALL_R
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   level_en,
  input  logic [1:0]             speed,
  input  logic [1:0]             obstacle_count,
  input  logic                   reset_level,
  input  logic [9:0]             ball_x,
  input  logic [9:0]             ball_y,
  output logic [NUM_SLOTS-1:0]   obst_valid,
  output logic [10*NUM_SLOTS-1:0] obst_x,
  output logic [10*NUM_SLOTS-1:0] obst_y,
  output logic                   sprite_collision,
  output logic [2:0]             active_count,
  output logic                   busy
);
  import game_pkg::*;
  localparam int IW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  sched_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic hit_q, hit_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0][9:0] x_q, x_d, y_q, y_d;
  logic [5:0] timer_q, timer_d;
  logic [1:0] lane_q, lane_d;
  logic coll_q;
  logic [9:0] step, cur_x, cur_y, new_x;
  logic retire, slot_hit, can_spawn, found;
  logic [5:0] timer_inc, period;
  logic [IW-1:0] free_idx;
  assign step = {7'd0, speed, 1'b0};
  assign cur_x = x_q[idx_q];
  assign cur_y = y_q[idx_q];
  assign new_x = cur_x - step;
  assign retire = cur_x < step;
  assign period = spawn_period(speed);
  assign timer_inc = timer_q + 6'd1;
  assign can_spawn = (timer_inc >= period) && (active_count < {1'b0, obstacle_count}) && found;
  // one comparator serves every slot as SCAN walks the index
  obstacle_hit_check #(.OBST_W(OBST_W), .BALL_R(BALL_R)) u_hit (
    .obj_x_i(new_x),
    .obj_y_i(cur_y),
    .ball_x_i(ball_x),
    .ball_y_i(ball_y),
    .hit_o(slot_hit)
  );
  always_comb begin
    found = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        found = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) active_count = active_count + {2'b0, valid_q[i]};
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hit_d = hit_q;
    valid_d = valid_q;
    x_d = x_q;
    y_d = y_q;
    timer_d = timer_q;
    lane_d = lane_q;
    unique case (state_q)
      WAIT: if (frame_tick && level_en && speed != 2'd0) begin
        state_d = SCAN;
        idx_d = '0;
        hit_d = 1'b0;
      end
      SCAN: begin
        if (valid_q[idx_q]) begin
          valid_d[idx_q] = !retire;
          x_d[idx_q] = retire ? cur_x : new_x;
          hit_d = hit_q || (!retire && slot_hit);
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_SLOTS - 1)) state_d = hit_d ? HIT : SPAWN;
      end
      SPAWN: begin
        state_d = WAIT;
        timer_d = timer_inc >= period ? period : timer_inc;
        if (can_spawn) begin
          valid_d[free_idx] = 1'b1;
          x_d[free_idx] = 10'(SCREEN_W - OBST_W);
          y_d[free_idx] = lane_y(lane_q);
          timer_d = '0;
          lane_d = lane_q + 2'd1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset || reset_level) begin
      state_q <= WAIT;
      idx_q <= '0;
      hit_q <= 1'b0;
      valid_q <= '0;
      x_q <= '0;
      y_q <= '0;
      timer_q <= '0;
      lane_q <= '0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      valid_q <= valid_d;
      x_q <= x_d;
      y_q <= y_d;
      timer_q <= timer_d;
      lane_q <= lane_d;
      coll_q <= (state_d == HIT) && (state_q != HIT);
    end
  end
  assign obst_valid = valid_q;
  assign obst_x = x_q;
  assign obst_y = y_q;
  assign sprite_collision = coll_q;
  assign busy = state_q != WAIT;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: frame-level reference model, per-cycle compare, directed and random stimulus
module tb_obstacle_scheduler;
  localparam int NS = 4;
  logic clk, reset, frame_tick, level_en, reset_level;
  logic [1:0] speed, obstacle_count;
  logic [9:0] ball_x, ball_y;
  logic [NS-1:0] obst_valid;
  logic [10*NS-1:0] obst_x, obst_y;
  logic sprite_collision, busy;
  logic [2:0] active_count;
  int total, bad;
  int mv[NS], mx[NS], my[NS];
  int mtimer, mlane, mphase, fstep;
  bit mfrozen, mcoll;

  obstacle_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .level_en(level_en),
    .speed(speed), .obstacle_count(obstacle_count), .reset_level(reset_level),
    .ball_x(ball_x), .ball_y(ball_y), .obst_valid(obst_valid), .obst_x(obst_x),
    .obst_y(obst_y), .sprite_collision(sprite_collision),
    .active_count(active_count), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int getx(input int i);
    return int'(obst_x[10*i +: 10]);
  endfunction
  function automatic int gety(input int i);
    return int'(obst_y[10*i +: 10]);
  endfunction
  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < NS; i++) c += mv[i];
    return c;
  endfunction

  // whole-frame model: a frame is accepted, moves land 4 edges later, the spawn one edge after
  always @(posedge clk) begin
    bit hit;
    int per;
    mcoll = 0;
    if (!reset || reset_level) begin
      for (int i = 0; i < NS; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end
      mtimer = 0; mlane = 0; mphase = 0; mfrozen = 0;
    end else if (mphase == 0) begin
      if (!mfrozen && frame_tick && level_en && speed != 0) begin
        mphase = 1;
        fstep = 2 * int'(speed);
      end
    end else if (mphase < 4) mphase++;
    else if (mphase == 4) begin
      hit = 0;
      for (int i = 0; i < NS; i++) if (mv[i] != 0) begin
        if (mx[i] < fstep) mv[i] = 0;
        else begin
          mx[i] -= fstep;
          if (ball_x + 4 >= mx[i] && ball_x < mx[i] + 20 && ball_y + 4 >= my[i] && ball_y < my[i] + 20) hit = 1;
        end
      end
      if (hit) begin mfrozen = 1; mcoll = 1; mphase = 0; end
      else mphase = 5;
    end else begin
      per = speed == 3 ? 16 : speed == 2 ? 32 : 48;
      mtimer++;
      if (mtimer >= per && mcount() < obstacle_count) begin
        for (int i = 0; i < NS; i++) if (mv[i] == 0) begin
          mv[i] = 1; mx[i] = 624; my[i] = 64 + 96 * mlane;
          mlane = (mlane + 1) % 4; mtimer = 0;
          break;
        end
      end else if (mtimer > per) mtimer = per;
      mphase = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (mphase != 0 || mfrozen) ? 1 : 0);
    chk("collision", sprite_collision, mcoll);
    if (mphase == 0 || mphase == 5) begin
      chk("active_count", active_count, mcount());
      for (int i = 0; i < NS; i++) begin
        chk("valid", obst_valid[i], mv[i]);
        if (mv[i] != 0) begin
          chk("x", getx(i), mx[i]);
          chk("y", gety(i), my[i]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick();
    frame_tick = 1; cyc(1); frame_tick = 0; cyc(8);
  endtask

  initial begin
    int rl, dt, n;
    reset = 0; frame_tick = 0; level_en = 1; speed = 1; obstacle_count = 1;
    reset_level = 0; ball_x = 0; ball_y = 0;
    cyc(3);
    reset = 1;
    chk("rst_valid", obst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_count, 0);
    chk("rst_coll", sprite_collision, 0);
    repeat (47) tick();
    chk("pre_spawn_valid", obst_valid, 0);
    tick();
    chk("spawn_valid", obst_valid, 4'b0001);
    chk("spawn_x", getx(0), 624);
    chk("spawn_y", gety(0), 64);
    tick();
    chk("move_x", getx(0), 622);
    for (n = 0; n < 400 && getx(0) != 100; n++) tick();
    chk("x_at_100", getx(0), 100);
    ball_x = 104; ball_y = 70;
    frame_tick = 1; cyc(1); frame_tick = 0;
    for (int k = 1; k <= 6; k++) begin
      chk("coll_timing", sprite_collision, k == 5);
      cyc(1);
    end
    chk("hit_x", getx(0), 98);
    chk("hit_busy", busy, 1);
    repeat (3) tick();
    chk("frozen_x", getx(0), 98);
    chk("frozen_valid", obst_valid[0], 1);
    reset_level = 1; cyc(1); reset_level = 0;
    chk("rl_valid", obst_valid, 0);
    chk("rl_busy", busy, 0);
    chk("rl_x", obst_x, 0);
    chk("rl_y", obst_y, 0);
    ball_x = 0; ball_y = 0; speed = 3; obstacle_count = 2;
    repeat (16) tick();
    chk("s3_x0", getx(0), 624);
    chk("s3_y0", gety(0), 64);
    repeat (16) tick();
    chk("two_active", active_count, 2);
    chk("s3_y1", gety(1), 160);
    obstacle_count = 1;
    repeat (50) tick();
    chk("no_removal", active_count, 2);
    for (n = 0; n < 100 && getx(0) != 6; n++) tick();
    chk("x_at_6", getx(0), 6);
    tick();
    chk("x_at_0", getx(0), 0);
    chk("x0_still_valid", obst_valid[0], 1);
    tick();
    chk("retired", obst_valid[0], 0);
    chk("retired_count", active_count, 1);
    repeat (5) tick();
    chk("count_block", active_count, 1);
    frame_tick = 1; cyc(1); frame_tick = 0; cyc(1);
    reset_level = 1; cyc(1); reset_level = 0;
    chk("abort_valid", obst_valid, 0);
    chk("abort_busy", busy, 0);
    cyc(8);
    repeat (16) tick();
    chk("lane_restart_y", gety(0), 64);
    chk("lane_restart_x", getx(0), 624);
    frame_tick = 1; cyc(1); frame_tick = 0; cyc(1); frame_tick = 1; cyc(1); frame_tick = 0; cyc(8);
    chk("drop_tick_x", getx(0), 618);
    for (int it = 0; it < 400; it++) begin
      level_en = $urandom_range(0, 9) != 0;
      speed = $urandom_range(0, 9) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
      obstacle_count = 2'($urandom_range(0, 3));
      ball_x = 10'($urandom_range(0, 640));
      ball_y = 10'(64 + 96 * $urandom_range(0, 3) + $urandom_range(0, 23) - 4);
      if ($urandom_range(0, 39) == 0) begin reset = 0; cyc(1); reset = 1; end
      rl = $urandom_range(0, 7) == 0 ? $urandom_range(1, 8) : 0;
      dt = $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0;
      frame_tick = 1; cyc(1);
      for (int k = 1; k <= 8; k++) begin
        frame_tick = k == dt;
        reset_level = k == rl;
        cyc(1);
      end
      frame_tick = 0; reset_level = 0;
    end
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
